// File: rtl/bmp180_pkg.sv
// rtl/bmp180_pkg.sv - shared constants, state codes and helpers for the BMP180 I2C responder
//
// Register map addresses, the CHIP_ID default, the soft-reset key and the
// FSM state codes that appear on the debug `state` port.

package bmp180_pkg;

    localparam logic [7:0] CHIP_ID_DEFAULT = 8'h55;
    localparam logic [7:0] SOFT_RESET_KEY  = 8'hB6;

    localparam logic [7:0] REG_CAL_FIRST  = 8'hAA;
    localparam logic [7:0] REG_CAL_LAST   = 8'hBF;
    localparam int         CAL_BYTES      = 22;
    localparam logic [7:0] REG_CHIP_ID    = 8'hD0;
    localparam logic [7:0] REG_SOFT_RESET = 8'hE0;
    localparam logic [7:0] REG_CTRL_MEAS  = 8'hF4;
    localparam logic [7:0] REG_OUT_MSB    = 8'hF6;
    localparam logic [7:0] REG_OUT_LSB    = 8'hF7;
    localparam logic [7:0] REG_OUT_XLSB   = 8'hF8;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } stateCode_e;

    function automatic logic isCalAdr(input logic [7:0] adr);
        return (adr >= REG_CAL_FIRST) && (adr <= REG_CAL_LAST);
    endfunction

    function automatic logic [4:0] calIndex(input logic [7:0] adr);
        return 5'(adr - REG_CAL_FIRST);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizers with edge and START/STOP detection
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   scl_in, sda_in      raw asynchronous bus lines
//   sdaLevel            synchronized SDA level
//   sclRise, sclFall    one-clk pulses on synchronized SCL edges
//   startDet, stopDet   one-clk pulses on SDA fall / rise while SCL stays high

module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sdaLevel,
    output logic sclRise,
    output logic sclFall,
    output logic startDet,
    output logic stopDet
);

    logic [1:0] sclMeta;
    logic [1:0] sdaMeta;
    logic       sclPrev;
    logic       sdaPrev;
    logic       sclLevel;

    // Everything resets to 1 so an idle bus produces no spurious edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclMeta <= 2'b11;
            sdaMeta <= 2'b11;
            sclPrev <= 1'b1;
            sdaPrev <= 1'b1;
        end else begin
            sclMeta <= {sclMeta[0], scl_in};
            sdaMeta <= {sdaMeta[0], sda_in};
            sclPrev <= sclMeta[1];
            sdaPrev <= sdaMeta[1];
        end
    end

    assign sclLevel = sclMeta[1];
    assign sdaLevel = sdaMeta[1];
    assign sclRise  = sclLevel & ~sclPrev;
    assign sclFall  = ~sclLevel & sclPrev;
    // SCL must be high on both samples so an SDA change racing an SCL edge is
    // not mistaken for a bus condition.
    assign startDet = sclLevel & sclPrev & sdaPrev & ~sdaLevel;
    assign stopDet  = sclLevel & sclPrev & ~sdaPrev & sdaLevel;

endmodule

// File: rtl/bmp180_i2c_responder.sv
// rtl/bmp180_i2c_responder.sv - I2C target model of the BMP180 register interface
//
// Ports:
//   clk, reset                 system clock (>= 16x SCL), synchronous active-high reset
//   scl_in, sda_in             asynchronous I2C lines
//   sda_oe                     1 pulls SDA low, 0 releases it
//   ld_adr, ld_data, ld_we     sensor-model load port for calibration / output registers
//   ctrl_meas                  current value of register 0xF4
//   meas_start                 one-clk pulse on every I2C write to 0xF4
//   busy                       high from an address-matched START until STOP
//   state                      debug view of the FSM state code

module bmp180_i2c_responder
    import bmp180_pkg::*;
#(
    parameter logic [6:0] DEV_ADR = 7'h77,
    parameter logic [7:0] CHIP_ID = CHIP_ID_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] ld_adr,
    input  logic [7:0] ld_data,
    input  logic       ld_we,
    output logic [7:0] ctrl_meas,
    output logic       meas_start,
    output logic       busy,
    output logic [3:0] state
);

    logic sdaLevel;
    logic sclRise;
    logic sclFall;
    logic startDet;
    logic stopDet;

    i2c_line_sync u_lineSync (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sdaLevel (sdaLevel),
        .sclRise  (sclRise),
        .sclFall  (sclFall),
        .startDet (startDet),
        .stopDet  (stopDet)
    );

    stateCode_e cur;
    logic [7:0] pointer;
    logic [7:0] rxShift;
    logic [6:0] txShift;    // bits still to send after the MSB already on the bus
    logic [3:0] bitCnt;
    logic       rwBit;
    logic       masterAck;
    logic [7:0] ctrlMeas;

    logic [7:0] calReg [CAL_BYTES];
    logic [7:0] outMsb;
    logic [7:0] outLsb;
    logic [7:0] outXlsb;

    logic [7:0] rdCur;
    logic [7:0] rdNext;
    logic       byteDone;

    function automatic logic [7:0] readReg(input logic [7:0] adr);
        logic [7:0] v;
        v = 8'h00;
        if (isCalAdr(adr)) begin
            v = calReg[calIndex(adr)];
        end else begin
            case (adr)
                REG_CHIP_ID:   v = CHIP_ID;
                REG_CTRL_MEAS: v = ctrlMeas;
                REG_OUT_MSB:   v = outMsb;
                REG_OUT_LSB:   v = outLsb;
                REG_OUT_XLSB:  v = outXlsb;
                default:       v = 8'h00;
            endcase
        end
        return v;
    endfunction

    always_comb begin
        rdCur  = readReg(pointer);
        rdNext = readReg(pointer + 8'd1);
    end

    // A received byte is complete on the SCL fall that follows its 8th rise;
    // acting on the fall lets the ACK states cover exactly the ACK clock.
    assign byteDone = sclFall && (bitCnt == 4'd8);

    // Sensor-model load port: only ld-only registers are reachable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CAL_BYTES; i++) begin
                calReg[i] <= 8'h00;
            end
            outMsb  <= 8'h00;
            outLsb  <= 8'h00;
            outXlsb <= 8'h00;
        end else if (ld_we) begin
            if (isCalAdr(ld_adr)) begin
                calReg[calIndex(ld_adr)] <= ld_data;
            end else begin
                case (ld_adr)
                    REG_OUT_MSB:  outMsb  <= ld_data;
                    REG_OUT_LSB:  outLsb  <= ld_data;
                    REG_OUT_XLSB: outXlsb <= ld_data;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= IDLE;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            meas_start <= 1'b0;
            ctrlMeas   <= 8'h00;
            pointer    <= 8'h00;
            rxShift    <= 8'h00;
            txShift    <= 7'h00;
            bitCnt     <= 4'd0;
            rwBit      <= 1'b0;
            masterAck  <= 1'b0;
        end else begin
            meas_start <= 1'b0;
            if (stopDet) begin
                cur    <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (startDet) begin
                cur    <= ADDR;
                bitCnt <= 4'd0;
                sda_oe <= 1'b0;
            end else begin
                if ((cur == ADDR || cur == PTR || cur == WDATA) && sclRise && bitCnt != 4'd8) begin
                    rxShift <= {rxShift[6:0], sdaLevel};
                    bitCnt  <= bitCnt + 4'd1;
                end

                case (cur)
                    ADDR: begin
                        if (byteDone) begin
                            bitCnt <= 4'd0;
                            if (rxShift[7:1] == DEV_ADR) begin
                                cur    <= ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rwBit  <= rxShift[0];
                            end else begin
                                cur <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (sclFall) begin
                            if (rwBit) begin
                                // Read: the MSB goes out on the same fall that ends the ACK.
                                cur     <= RDATA;
                                txShift <= rdCur[6:0];
                                sda_oe  <= ~rdCur[7];
                                bitCnt  <= 4'd1;
                            end else begin
                                cur    <= PTR;
                                sda_oe <= 1'b0;
                                bitCnt <= 4'd0;
                            end
                        end
                    end
                    PTR: begin
                        if (byteDone) begin
                            pointer <= rxShift;
                            bitCnt  <= 4'd0;
                            cur     <= PTR_ACK;
                            sda_oe  <= 1'b1;
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (sclFall) begin
                            cur    <= WDATA;
                            sda_oe <= 1'b0;
                        end
                    end
                    WDATA: begin
                        if (byteDone) begin
                            if (pointer == REG_CTRL_MEAS) begin
                                ctrlMeas   <= rxShift;
                                meas_start <= 1'b1;
                            end else if (pointer == REG_SOFT_RESET && rxShift == SOFT_RESET_KEY) begin
                                ctrlMeas <= 8'h00;
                            end
                            pointer <= pointer + 8'd1;
                            bitCnt  <= 4'd0;
                            cur     <= WDATA_ACK;
                            sda_oe  <= 1'b1;
                        end
                    end
                    RDATA: begin
                        if (sclFall) begin
                            if (bitCnt == 4'd8) begin
                                cur    <= RDATA_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                sda_oe  <= ~txShift[6];
                                txShift <= {txShift[5:0], 1'b0};
                                bitCnt  <= bitCnt + 4'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (sclRise) begin
                            masterAck <= ~sdaLevel;
                        end
                        if (sclFall) begin
                            // The pointer moves past every byte read, so a later
                            // current-address read continues after the last byte.
                            pointer <= pointer + 8'd1;
                            if (masterAck) begin
                                cur     <= RDATA;
                                txShift <= rdNext[6:0];
                                sda_oe  <= ~rdNext[7];
                                bitCnt  <= 4'd1;
                            end else begin
                                cur    <= IGNORE;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    IDLE, IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        cur    <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ctrl_meas = ctrlMeas;
    assign state     = cur;

endmodule

// File: tb/tb_bmp180_i2c_responder.sv
// tb/tb_bmp180_i2c_responder.sv - self-checking bench for bmp180_i2c_responder

module tb_bmp180_i2c_responder;
    import bmp180_pkg::*;

    localparam int Q = 5;   // quarter SCL period in clk cycles (SCL = clk/20)

    logic       clk = 1'b0;
    logic       reset;
    logic       sclM;
    logic       sdaM;
    logic       sdaBus;
    logic       sda_oe;
    logic [7:0] ld_adr;
    logic [7:0] ld_data;
    logic       ld_we;
    logic [7:0] ctrl_meas;
    logic       meas_start;
    logic       busy;
    logic [3:0] state;

    always #5 clk = ~clk;

    // Open-drain bus: either side may pull low.
    assign sdaBus = sdaM & ~sda_oe;

    bmp180_i2c_responder dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (sclM),
        .sda_in     (sdaBus),
        .sda_oe     (sda_oe),
        .ld_adr     (ld_adr),
        .ld_data    (ld_data),
        .ld_we      (ld_we),
        .ctrl_meas  (ctrl_meas),
        .meas_start (meas_start),
        .busy       (busy),
        .state      (state)
    );

    int checks = 0;
    int errors = 0;

    int measPulses = 0;
    int oeCount    = 0;
    int busyCount  = 0;
    always @(negedge clk) begin
        if (meas_start) measPulses++;
        if (sda_oe)     oeCount++;
        if (busy)       busyCount++;
    end

    // Reference model of the register file as seen from the bus.
    logic [7:0] mCal [22];
    logic [7:0] mOut [3];
    logic [7:0] mCtrl;
    logic [7:0] mPtr;
    int         mMeas = 0;

    function automatic logic [7:0] modelRead(input logic [7:0] a);
        if (a >= 8'hAA && a <= 8'hBF) return mCal[int'(a) - 'hAA];
        if (a == 8'hD0) return 8'h55;
        if (a == 8'hF4) return mCtrl;
        if (a >= 8'hF6 && a <= 8'hF8) return mOut[int'(a) - 'hF6];
        return 8'h00;
    endfunction

    function automatic void modelLoad(input logic [7:0] a, input logic [7:0] d);
        if (a >= 8'hAA && a <= 8'hBF) mCal[int'(a) - 'hAA] = d;
        else if (a >= 8'hF6 && a <= 8'hF8) mOut[int'(a) - 'hF6] = d;
    endfunction

    function automatic void modelWrite(input logic [7:0] d);
        if (mPtr == 8'hF4) begin
            mCtrl = d;
            mMeas++;
        end else if (mPtr == 8'hE0 && d == 8'hB6) begin
            mCtrl = 8'h00;
        end
        mPtr = mPtr + 8'd1;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 22; i++) mCal[i] = 8'h00;
        for (int i = 0; i < 3; i++) mOut[i] = 8'h00;
        mCtrl = 8'h00;
        mPtr  = 8'h00;
    endfunction

    // ---------------- bus master ----------------
    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    task automatic busStart();
        sdaM = 1'b1; waitQ();
        sclM = 1'b1; waitQ();
        sdaM = 1'b0; waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic busStop();
        sdaM = 1'b0; waitQ();
        sclM = 1'b1; waitQ();
        sdaM = 1'b1; waitQ();
        waitQ();
    endtask

    task automatic sendBit(input logic b);
        sdaM = b; waitQ();
        sclM = 1'b1; waitQ(); waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic recvBit(output logic b);
        sdaM = 1'b1; waitQ();
        sclM = 1'b1; waitQ();
        b = sdaBus; waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic loadReg(input logic [7:0] a, input logic [7:0] d);
        ld_adr = a; ld_data = d; ld_we = 1'b1;
        @(negedge clk);
        ld_we = 1'b0;
        modelLoad(a, d);
    endtask

    task automatic sendByte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) sendBit(d[i]);
        recvBit(b);
        ack = ~b;
    endtask

    task automatic recvByte(input logic mack, input int ldBit, input logic [7:0] ldA,
                            input logic [7:0] ldD, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            if (i == ldBit) loadReg(ldA, ldD);
            recvBit(b);
            d[i] = b;
        end
        sendBit(~mack);
    endtask

    logic [7:0] rdBuf[$];
    logic [7:0] expBuf[$];
    logic [7:0] wrBuf[$];
    int         ackCnt;

    // Read n bytes, NACKing the last; optional ld_we during byte ldByte at bit ldBit.
    task automatic doRead(input bit setPtr, input logic [7:0] ptr, input int n,
                          input int ldByte, input int ldBit, input logic [7:0] ldA,
                          input logic [7:0] ldD);
        logic a;
        logic [7:0] d;
        rdBuf.delete();
        expBuf.delete();
        ackCnt = 0;
        busStart();
        if (setPtr) begin
            sendByte(8'hEE, a); ackCnt += int'(a);
            sendByte(ptr, a);   ackCnt += int'(a);
            mPtr = ptr;
            busStart();
        end
        sendByte(8'hEF, a); ackCnt += int'(a);
        for (int i = 0; i < n; i++) begin
            expBuf.push_back(modelRead(mPtr));
            mPtr = mPtr + 8'd1;
            recvByte(i != n - 1, (i == ldByte) ? ldBit : -1, ldA, ldD, d);
            rdBuf.push_back(d);
        end
        busStop();
    endtask

    task automatic doWrite(input logic [7:0] ptr);
        logic a;
        ackCnt = 0;
        busStart();
        sendByte(8'hEE, a); ackCnt += int'(a);
        sendByte(ptr, a);   ackCnt += int'(a);
        mPtr = ptr;
        foreach (wrBuf[i]) begin
            sendByte(wrBuf[i], a); ackCnt += int'(a);
            modelWrite(wrBuf[i]);
        end
        busStop();
    endtask

    function automatic logic [7:0] pickAdr();
        case ($urandom_range(0, 5))
            0:       return 8'hAA + 8'($urandom_range(0, 21));
            1:       return 8'hD0;
            2:       return 8'hE0;
            3:       return 8'hF3 + 8'($urandom_range(0, 6));
            4:       return 8'hFE + 8'($urandom_range(0, 1));
            default: return 8'($urandom());
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (state !== 4'(IDLE)) begin errors++; $display("FAIL reset_state got %0d want %0d", state, IDLE); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (meas_start !== 1'b0) begin errors++; $display("FAIL reset_meas_start got %b want 0", meas_start); end
        checks++; if (ctrl_meas !== 8'h00) begin errors++; $display("FAIL reset_ctrl_meas got %h want 00", ctrl_meas); end
        reset = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        doRead(1'b0, 8'h00, 1, -1, -1, 8'h00, 8'h00);
        checks++; if (rdBuf[0] !== 8'h00) begin errors++; $display("FAIL reset_ptr0_read got %h want 00", rdBuf[0]); end
        doRead(1'b1, 8'hAA, 1, -1, -1, 8'h00, 8'h00);
        checks++; if (rdBuf[0] !== 8'h00) begin errors++; $display("FAIL reset_cal_read got %h want 00", rdBuf[0]); end
    endtask

    task automatic test_id_read();
        logic a;
        logic [7:0] d;
        int acks;
        acks = 0;
        busStart();
        sendByte(8'hEE, a); acks += int'(a);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL id_busy got %b want 1", busy); end
        sendByte(8'hD0, a); acks += int'(a);
        busStart();
        sendByte(8'hEF, a); acks += int'(a);
        recvByte(1'b0, -1, 8'h00, 8'h00, d);
        busStop();
        mPtr = 8'hD1;
        checks++; if (acks != 3) begin errors++; $display("FAIL id_acks got %0d want 3", acks); end
        checks++; if (d !== 8'h55) begin errors++; $display("FAIL id_data got %h want 55", d); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL id_busy_after_stop got %b want 0", busy); end
        checks++; if (state !== 4'(IDLE)) begin errors++; $display("FAIL id_state_after_stop got %0d want %0d", state, IDLE); end
    endtask

    task automatic test_pointer_advance();
        doRead(1'b1, 8'hD0, 1, -1, -1, 8'h00, 8'h00);
        checks++; if (rdBuf[0] !== 8'h55) begin errors++; $display("FAIL adv_first got %h want 55", rdBuf[0]); end
        doRead(1'b0, 8'h00, 1, -1, -1, 8'h00, 8'h00);
        checks++; if (rdBuf[0] !== 8'h00) begin errors++; $display("FAIL adv_next got %h want 00", rdBuf[0]); end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 22; i++) loadReg(8'hAA + 8'(i), 8'(i + 1));
        doRead(1'b1, 8'hAA, 22, -1, -1, 8'h00, 8'h00);
        checks++; if (ackCnt != 3) begin errors++; $display("FAIL burst_acks got %0d want 3", ackCnt); end
        checks++;
        if (rdBuf.size() != 22) begin
            errors++; $display("FAIL burst_len got %0d want 22", rdBuf.size());
        end else begin
            for (int i = 0; i < 22; i++) begin
                checks++;
                if (rdBuf[i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL burst_byte%0d got %h want %h", i, rdBuf[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_control();
        int m0;
        m0 = measPulses;
        wrBuf = '{8'h2E};
        doWrite(8'hF4);
        checks++; if (ackCnt != 3) begin errors++; $display("FAIL ctrl_acks got %0d want 3", ackCnt); end
        checks++; if (ctrl_meas !== 8'h2E) begin errors++; $display("FAIL ctrl_meas_write got %h want 2e", ctrl_meas); end
        checks++; if (measPulses - m0 != 1) begin errors++; $display("FAIL ctrl_meas_pulses got %0d want 1", measPulses - m0); end
        wrBuf = '{8'h12};
        doWrite(8'hE0);
        checks++; if (ctrl_meas !== 8'h2E) begin errors++; $display("FAIL ctrl_bad_key got %h want 2e", ctrl_meas); end
        wrBuf = '{8'hB6};
        doWrite(8'hE0);
        checks++; if (ctrl_meas !== 8'h00) begin errors++; $display("FAIL ctrl_soft_reset got %h want 00", ctrl_meas); end
        checks++; if (measPulses - m0 != 1) begin errors++; $display("FAIL ctrl_pulses_total got %0d want 1", measPulses - m0); end
        doRead(1'b1, 8'hAB, 1, -1, -1, 8'h00, 8'h00);
        checks++; if (rdBuf[0] !== 8'h02) begin errors++; $display("FAIL ctrl_cal_kept got %h want 02", rdBuf[0]); end
    endtask

    task automatic test_wrong_addr();
        logic a;
        int oe0, busy0;
        oe0 = oeCount;
        busy0 = busyCount;
        busStart();
        sendByte(8'hEC, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack got %b want 0", a); end
        checks++; if (state !== 4'(IGNORE)) begin errors++; $display("FAIL wrong_addr_state got %0d want %0d", state, IGNORE); end
        sendByte(8'h00, a);
        busStop();
        checks++; if (oeCount != oe0) begin errors++; $display("FAIL wrong_addr_oe got %0d want %0d", oeCount, oe0); end
        checks++; if (busyCount != busy0) begin errors++; $display("FAIL wrong_addr_busy got %0d want %0d", busyCount, busy0); end
    endtask

    task automatic test_wrap();
        doRead(1'b1, 8'hFF, 2, -1, -1, 8'h00, 8'h00);
        checks++; if (rdBuf[0] !== 8'h00) begin errors++; $display("FAIL wrap_b0 got %h want 00", rdBuf[0]); end
        checks++; if (rdBuf[1] !== 8'h00) begin errors++; $display("FAIL wrap_b1 got %h want 00", rdBuf[1]); end
        checks++; if (mPtr !== 8'h01) begin errors++; $display("FAIL wrap_model_ptr got %h want 01", mPtr); end
        doRead(1'b0, 8'h00, 1, -1, -1, 8'h00, 8'h00);
        checks++; if (rdBuf[0] !== 8'h00) begin errors++; $display("FAIL wrap_next got %h want 00", rdBuf[0]); end
    endtask

    task automatic test_ld_during_read();
        loadReg(8'hF6, 8'h12);
        loadReg(8'hF7, 8'h9A);
        doRead(1'b1, 8'hF6, 2, 0, 4, 8'hF6, 8'h34);
        checks++; if (rdBuf[0] !== 8'h12) begin errors++; $display("FAIL ld_same_byte got %h want 12", rdBuf[0]); end
        checks++; if (rdBuf[1] !== 8'h9A) begin errors++; $display("FAIL ld_b1 got %h want 9a", rdBuf[1]); end
        doRead(1'b1, 8'hF6, 2, 0, 3, 8'hF7, 8'hC3);
        checks++; if (rdBuf[0] !== 8'h34) begin errors++; $display("FAIL ld_new_b0 got %h want 34", rdBuf[0]); end
        checks++; if (rdBuf[1] !== 8'hC3) begin errors++; $display("FAIL ld_next_byte got %h want c3", rdBuf[1]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0: loadReg(pickAdr(), 8'($urandom()));
                1: begin
                    int n;
                    n = $urandom_range(1, 3);
                    wrBuf.delete();
                    for (int k = 0; k < n; k++)
                        wrBuf.push_back(($urandom_range(0, 3) == 0) ? 8'hB6 : 8'($urandom()));
                    doWrite(pickAdr());
                    checks++; if (ackCnt != 2 + n) begin errors++; $display("FAIL rnd_w_acks got %0d want %0d", ackCnt, 2 + n); end
                    checks++; if (ctrl_meas !== mCtrl) begin errors++; $display("FAIL rnd_ctrl_meas got %h want %h", ctrl_meas, mCtrl); end
                    checks++; if (measPulses != mMeas) begin errors++; $display("FAIL rnd_meas_pulses got %0d want %0d", measPulses, mMeas); end
                end
                default: begin
                    int n;
                    n = $urandom_range(1, 4);
                    doRead($urandom_range(0, 2) != 0, pickAdr(), n, $urandom_range(0, 4),
                           $urandom_range(0, 7), pickAdr(), 8'($urandom()));
                    for (int k = 0; k < n; k++) begin
                        checks++;
                        if (rdBuf[k] !== expBuf[k]) begin
                            errors++; $display("FAIL rnd_read it%0d byte%0d got %h want %h", it, k, rdBuf[k], expBuf[k]);
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        logic b;
        int oe0;
        busStart();
        sendByte(8'hEE, a);
        sendByte(8'hD0, a);
        busStart();
        sendByte(8'hEF, a);
        // 0x55 has MSB 0, so the responder is now holding SDA low.
        checks++; if (state !== 4'(RDATA)) begin errors++; $display("FAIL rst_pre_state got %0d want %0d", state, RDATA); end
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_pre_sda_oe got %b want 1", sda_oe); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
        checks++; if (state !== 4'(IDLE)) begin errors++; $display("FAIL rst_state got %0d want %0d", state, IDLE); end
        oe0 = oeCount;
        for (int i = 0; i < 9; i++) recvBit(b);
        checks++; if (oeCount != oe0) begin errors++; $display("FAIL rst_bus_ignored got %0d want %0d", oeCount, oe0); end
        busStop();
        checks++; if (ctrl_meas !== 8'h00) begin errors++; $display("FAIL rst_ctrl_meas got %h want 00", ctrl_meas); end
        doRead(1'b1, 8'hD0, 1, -1, -1, 8'h00, 8'h00);
        checks++; if (rdBuf[0] !== 8'h55) begin errors++; $display("FAIL rst_after_read got %h want 55", rdBuf[0]); end
    endtask

    initial begin
        sclM   = 1'b1;
        sdaM   = 1'b1;
        ld_adr = 8'h00;
        ld_data = 8'h00;
        ld_we  = 1'b0;
        reset  = 1'b1;
        modelReset();
        test_reset();
        test_id_read();
        test_pointer_advance();
        test_burst();
        test_control();
        test_wrong_addr();
        test_wrap();
        test_ld_during_read();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bmp180_i2c_responder.md
BMP180_I2C_RESPONDER -- requirements
Module: bmp180_i2c_responder

Interface
REQ-001 SHALL have parameter DEV_ADR, default 7'h77, 7-bit target address answered.
REQ-002 SHALL have parameter CHIP_ID, default 8'h55, value returned at register 0xD0.
REQ-003 SHALL have port clk  in  1  single system clock, all logic on rising edge; clk >= 16x SCL rate.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port scl_in  in  1  I2C clock line, asynchronous.
REQ-006 SHALL have port sda_in  in  1  I2C data line, asynchronous.
REQ-007 SHALL have port sda_oe  out  1  1 = pull SDA low (open drain), 0 = release.
REQ-008 SHALL have ports ld_adr  in  8, ld_data  in  8, ld_we  in  1  sensor-model load of register file.
REQ-009 SHALL have port ctrl_meas  out  8  current value of register 0xF4.
REQ-010 SHALL have port meas_start  out  1  one-clk pulse on every I2C write to 0xF4.
REQ-011 SHALL have port busy  out  1  high from address-matched START until STOP.
REQ-012 SHALL have port state  out  4  current FSM state code, debug.

Function
REQ-013 SHALL pass scl_in/sda_in through 2-flop synchronizers; edges and conditions use synchronized values only.
REQ-014 SHALL detect START as SDA fall while SCL high and STOP as SDA rise while SCL high.
REQ-015 SHALL sample bits on SCL rising edge and change sda_oe only in the clk after an SCL falling edge.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-017 SHALL enter ADDR on START or repeated START from any state, clearing bit counter.
REQ-018 SHALL, after 8 address bits, ACK (sda_oe=1 for one SCL period) only if bits[7:1]==DEV_ADR, else go IGNORE with no ACK.
REQ-019 SHALL, on write address, go PTR; the first data byte loads the register pointer and is ACKed.
REQ-020 SHALL, on subsequent write bytes, ACK each, store to pointer if writable, then increment pointer.
REQ-021 SHALL, on read address, drive MSB of reg[pointer] at the SCL fall ending ADDR_ACK, shift per fall, release SDA after bit 0.
REQ-022 SHALL sample master ACK in RDATA_ACK: ACK -> increment pointer, next byte; NACK -> IGNORE.
REQ-023 SHALL wrap pointer 0xFF -> 0x00 on increment.
REQ-024 SHALL map: 0xAA-0xBF calibration (22 bytes, ld-only), 0xD0 CHIP_ID (ro), 0xE0 soft reset (wo, reads 0x00), 0xF4 ctrl_meas (rw), 0xF6-0xF8 out_msb/lsb/xlsb (ld-only); all other addresses read 0x00, writes ignored.
REQ-025 SHALL on I2C write of 0xB6 to 0xE0 clear ctrl_meas to 0x00; other values ignored; calibration untouched.
REQ-026 SHALL apply ld_we writes only to ld-only addresses, same clk, any time; ld_adr elsewhere ignored.
REQ-027 SHALL latch the read byte into the shift register at byte start; ld_we during a byte affects next byte only.
REQ-028 SHALL return to IDLE, release SDA and drop busy on STOP in any state.
REQ-029 SHALL keep sda_oe=0 in IDLE and IGNORE.

Reset
REQ-030 SHALL on reset: state IDLE, sda_oe 0, busy 0, meas_start 0, ctrl_meas 0x00, pointer 0x00, out regs 0x00, calibration 0x00, synchronizers 1.
REQ-031 SHALL, on reset mid-transfer, release SDA in the following clk and ignore bus until next START.

Structure
REQ-032 SHALL place register address constants, CHIP_ID default, soft-reset key 0xB6 and state codes in shared package bmp180_pkg.
REQ-033 SHALL use one sub-module i2c_line_sync (synchronizers, edge, START/STOP detect).

Verification
REQ-034 SHALL test ID read: W 0xEE, 0xD0, Sr 0xEF, read 1 NACK -> data 0x55, three ACKs from DUT.
REQ-035 SHALL test burst: ld 0xAA..0xBF = 0x01..0x16, read 22 bytes from 0xAA -> 0x01..0x16 in order, NACK last.
REQ-036 SHALL test control: write 0xF4=0x2E -> ctrl_meas 0x2E, single meas_start pulse; write 0xE0=0xB6 -> ctrl_meas 0x00.
REQ-037 SHALL test wrong address: 0xEC -> no ACK, sda_oe 0 until STOP, busy 0.
REQ-038 SHALL test wrap: pointer 0xFF, read 2 bytes -> 0x00, 0x00, pointer ends 0x01 (next read 0x00).
REQ-039 SHALL test reset asserted during RDATA with SDA low -> sda_oe 0 next clk, state IDLE.
